// File: rtl/fft_streaming_pipo_multibuf.sv
`default_nettype none
// ============================================================================
// Module  : fft_streaming_pipo_multibuf
// Brief   : BUFFER_COUNT-deep ping-pong frame channel between two FFT stages,
//           two registered-read ports per side. Optional flush: FFT_PIPO_FLUSH_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fft_streaming_pipo_multibuf #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_RANGE = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int BUFFER_COUNT  = 3,
    parameter int INDEX_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    // producer side
    input  logic                     i_ce,
    input  logic                     i_write,
    output logic                     i_full_n,
    input  logic                     i_ce0,
    input  logic                     i_we0,
    input  logic [ADDRESS_WIDTH-1:0] i_address0,
    input  logic [DATA_WIDTH-1:0]    i_d0,
    output logic [DATA_WIDTH-1:0]    i_q0,
    input  logic                     i_ce1,
    input  logic                     i_we1,
    input  logic [ADDRESS_WIDTH-1:0] i_address1,
    input  logic [DATA_WIDTH-1:0]    i_d1,
    output logic [DATA_WIDTH-1:0]    i_q1,
    // consumer side
    input  logic                     t_ce,
    input  logic                     t_read,
    output logic                     t_empty_n,
    input  logic                     t_ce0,
    input  logic                     t_we0,
    input  logic [ADDRESS_WIDTH-1:0] t_address0,
    input  logic [DATA_WIDTH-1:0]    t_d0,
    output logic [DATA_WIDTH-1:0]    t_q0,
    input  logic                     t_ce1,
    input  logic                     t_we1,
    input  logic [ADDRESS_WIDTH-1:0] t_address1,
    input  logic [DATA_WIDTH-1:0]    t_d1,
    output logic [DATA_WIDTH-1:0]    t_q1,
`ifdef FFT_PIPO_FLUSH_EN
    input  logic                     t_flush,
`endif
    output logic [INDEX_WIDTH:0]     occupancy
);

    localparam int MEM_DEPTH = BUFFER_COUNT * ADDRESS_RANGE;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int NPORTS    = 4;

    logic [INDEX_WIDTH-1:0]   r_iptr;
    logic [INDEX_WIDTH-1:0]   r_tptr;
    logic [INDEX_WIDTH:0]     r_count;
    logic                     r_full_n;
    logic                     r_empty_n;

    logic                     w_push;
    logic                     w_pop;

    logic [NPORTS-1:0]        w_ce;
    logic [NPORTS-1:0]        w_we;
    logic [NPORTS-1:0]        w_inr;
    logic [ADDRESS_WIDTH-1:0] w_addr [NPORTS];
    logic [DATA_WIDTH-1:0]    w_d    [NPORTS];
    logic [INDEX_WIDTH-1:0]   w_ptr  [NPORTS];
    logic [MEM_AW-1:0]        w_idx  [NPORTS];
    logic [DATA_WIDTH-1:0]    r_q    [NPORTS];

    logic [DATA_WIDTH-1:0]    r_mem  [MEM_DEPTH];

    function automatic logic [INDEX_WIDTH-1:0] f_next(input logic [INDEX_WIDTH-1:0] p);
        return (p == INDEX_WIDTH'(BUFFER_COUNT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = i_ce & i_write & r_full_n;
    assign w_pop  = t_ce & t_read & r_empty_n;

    // Port order 0..3 = producer 0/1, consumer 0/1; higher index wins on writes.
    assign w_ce = {t_ce1 & r_empty_n, t_ce0 & r_empty_n, i_ce1 & r_full_n, i_ce0 & r_full_n};
    assign w_we = w_ce & {t_we1, t_we0, i_we1, i_we0};

    assign w_addr[0] = i_address0;
    assign w_addr[1] = i_address1;
    assign w_addr[2] = t_address0;
    assign w_addr[3] = t_address1;

    assign w_d[0] = i_d0;
    assign w_d[1] = i_d1;
    assign w_d[2] = t_d0;
    assign w_d[3] = t_d1;

    assign w_ptr[0] = r_iptr;
    assign w_ptr[1] = r_iptr;
    assign w_ptr[2] = r_tptr;
    assign w_ptr[3] = r_tptr;

    always_comb begin
        w_inr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_inr[p] = ({1'b0, w_addr[p]} < (ADDRESS_WIDTH + 1)'(ADDRESS_RANGE));
            w_idx[p] = MEM_AW'(w_ptr[p]) * MEM_AW'(ADDRESS_RANGE) + MEM_AW'(w_addr[p]);
        end
    end

    // Frame storage; never reset, contents survive until overwritten.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (w_we[p] && w_inr[p]) begin
                r_mem[w_idx[p]] <= w_d[p];
            end
        end
    end

    // Read-first: the q register captures the word present before this edge.
    // The pointer used here is the one sampled at the access edge, so a
    // simultaneous pointer advance cannot redirect data already in flight.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (reset) begin
                r_q[p] <= '0;
            end else if (w_ce[p]) begin
                r_q[p] <= w_inr[p] ? r_mem[w_idx[p]] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iptr    <= '0;
            r_tptr    <= '0;
            r_count   <= '0;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
        end
`ifdef FFT_PIPO_FLUSH_EN
        else if (t_flush) begin
            r_tptr    <= r_iptr;
            r_count   <= '0;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
        end
`endif
        else begin
            if (w_push) begin
                r_iptr <= f_next(r_iptr);
            end
            if (w_pop) begin
                r_tptr <= f_next(r_tptr);
            end
            if (w_push && !w_pop) begin
                r_count   <= r_count + 1'b1;
                r_empty_n <= 1'b1;
                if (r_count == (INDEX_WIDTH + 1)'(BUFFER_COUNT - 1)) begin
                    r_full_n <= 1'b0;
                end
            end else if (w_pop && !w_push) begin
                r_count  <= r_count - 1'b1;
                r_full_n <= 1'b1;
                if (r_count == (INDEX_WIDTH + 1)'(1)) begin
                    r_empty_n <= 1'b0;
                end
            end
        end
    end

    assign i_full_n  = r_full_n;
    assign t_empty_n = r_empty_n;
    assign occupancy = r_count;
    assign i_q0      = r_q[0];
    assign i_q1      = r_q[1];
    assign t_q0      = r_q[2];
    assign t_q1      = r_q[3];

endmodule
`default_nettype wire

// File: tb/tb_fft_streaming_pipo_multibuf.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_streaming_pipo_multibuf
// Brief   : Directed bench with a frame-level reference model for the PIPO
//           channel. Define FFT_PIPO_FLUSH_EN to also exercise flush.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_streaming_pipo_multibuf;

    localparam int DW = 32;
    localparam int AR = 32;
    localparam int AW = 6;
    localparam int BC = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          i_ce, i_write, i_full_n;
    logic          i_ce0, i_we0, i_ce1, i_we1;
    logic [AW-1:0] i_address0, i_address1;
    logic [DW-1:0] i_d0, i_d1, i_q0, i_q1;
    logic          t_ce, t_read, t_empty_n;
    logic          t_ce0, t_we0, t_ce1, t_we1;
    logic [AW-1:0] t_address0, t_address1;
    logic [DW-1:0] t_d0, t_d1, t_q0, t_q1;
    logic [IW:0]   occupancy;
`ifdef FFT_PIPO_FLUSH_EN
    logic          t_flush;
`endif

    fft_streaming_pipo_multibuf #(
        .DATA_WIDTH   (DW),
        .ADDRESS_RANGE(AR),
        .ADDRESS_WIDTH(AW),
        .BUFFER_COUNT (BC),
        .INDEX_WIDTH  (IW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .i_ce      (i_ce),
        .i_write   (i_write),
        .i_full_n  (i_full_n),
        .i_ce0     (i_ce0),
        .i_we0     (i_we0),
        .i_address0(i_address0),
        .i_d0      (i_d0),
        .i_q0      (i_q0),
        .i_ce1     (i_ce1),
        .i_we1     (i_we1),
        .i_address1(i_address1),
        .i_d1      (i_d1),
        .i_q1      (i_q1),
        .t_ce      (t_ce),
        .t_read    (t_read),
        .t_empty_n (t_empty_n),
        .t_ce0     (t_ce0),
        .t_we0     (t_we0),
        .t_address0(t_address0),
        .t_d0      (t_d0),
        .t_q0      (t_q0),
        .t_ce1     (t_ce1),
        .t_we1     (t_we1),
        .t_address1(t_address1),
        .t_d1      (t_d1),
        .t_q1      (t_q1),
`ifdef FFT_PIPO_FLUSH_EN
        .t_flush   (t_flush),
`endif
        .occupancy (occupancy)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: frames as a 2-D array, channel as a simple counter.
    logic [DW-1:0] mem_m [BC][AR];
    bit            mem_v [BC][AR];
    int            cnt_m = 0;
    int            ip_m  = 0;
    int            tp_m  = 0;
    logic [DW-1:0] q_m  [4];
    bit            qk_m [4];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        i_ce = 0; i_write = 0; i_ce0 = 0; i_we0 = 0; i_ce1 = 0; i_we1 = 0;
        i_address0 = '0; i_address1 = '0; i_d0 = '0; i_d1 = '0;
        t_ce = 0; t_read = 0; t_ce0 = 0; t_we0 = 0; t_ce1 = 0; t_we1 = 0;
        t_address0 = '0; t_address1 = '0; t_d0 = '0; t_d1 = '0;
`ifdef FFT_PIPO_FLUSH_EN
        t_flush = 0;
`endif
    endtask

    // Advance one clock, updating the model from the inputs of this cycle.
    task automatic step();
        logic [DW-1:0] nq [4];
        bit            nk [4];
        bit            ce [4];
        bit            we [4];
        int            ad [4];
        logic [DW-1:0] dd [4];
        int            bf [4];
        bit            fn, en, push, pop, fl;
        fn = (cnt_m < BC);
        en = (cnt_m > 0);
        ce = '{i_ce0 & fn, i_ce1 & fn, t_ce0 & en, t_ce1 & en};
        we = '{i_we0, i_we1, t_we0, t_we1};
        ad = '{int'(i_address0), int'(i_address1), int'(t_address0), int'(t_address1)};
        dd = '{i_d0, i_d1, t_d0, t_d1};
        bf = '{ip_m, ip_m, tp_m, tp_m};
        for (int p = 0; p < 4; p++) begin
            nq[p] = q_m[p];
            nk[p] = qk_m[p];
            if (ce[p]) begin
                if (ad[p] < AR) begin
                    nq[p] = mem_m[bf[p]][ad[p]];
                    nk[p] = mem_v[bf[p]][ad[p]];
                end else begin
                    nq[p] = '0;
                    nk[p] = 1'b1;
                end
            end
        end
        push = i_ce & i_write & fn;
        pop  = t_ce & t_read & en;
        fl   = 1'b0;
`ifdef FFT_PIPO_FLUSH_EN
        fl   = t_flush;
`endif
        @(posedge clk);
        if (reset) begin
            cnt_m = 0; ip_m = 0; tp_m = 0;
            for (int p = 0; p < 4; p++) begin
                q_m[p]  = '0;
                qk_m[p] = 1'b1;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (ce[p] && we[p] && ad[p] < AR) begin
                    mem_m[bf[p]][ad[p]] = dd[p];
                    mem_v[bf[p]][ad[p]] = 1'b1;
                end
                q_m[p]  = nq[p];
                qk_m[p] = nk[p];
            end
            if (fl) begin
                cnt_m = 0;
                tp_m  = ip_m;
            end else begin
                if (push) ip_m = (ip_m + 1) % BC;
                if (pop)  tp_m = (tp_m + 1) % BC;
                cnt_m = cnt_m + int'(push) - int'(pop);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("occupancy", 32'(occupancy), 32'(cnt_m));
            cmp("i_full_n", 32'(i_full_n), 32'(cnt_m < BC));
            cmp("t_empty_n", 32'(t_empty_n), 32'(cnt_m > 0));
            if (qk_m[0]) cmp("i_q0", i_q0, q_m[0]);
            if (qk_m[1]) cmp("i_q1", i_q1, q_m[1]);
            if (qk_m[2]) cmp("t_q0", t_q0, q_m[2]);
            if (qk_m[3]) cmp("t_q1", t_q1, q_m[3]);
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        cmp("rst_occ", 32'(occupancy), 32'd0);
        cmp("rst_full_n", 32'(i_full_n), 32'd1);
        cmp("rst_empty_n", 32'(t_empty_n), 32'd0);
        cmp("rst_tq0", t_q0, 32'd0);

        // frame 0: port writes, collision, out-of-range, read-first
        i_ce0 = 1; i_we0 = 1; i_address0 = 6'd4; i_d0 = 32'h5A;
        step(); idle();
        i_ce0 = 1; i_we0 = 1; i_address0 = 6'd7; i_d0 = 32'h11;
        i_ce1 = 1; i_we1 = 1; i_address1 = 6'd7; i_d1 = 32'h22;
        step(); idle();
        i_ce0 = 1; i_we0 = 1; i_address0 = 6'd40; i_d0 = 32'hDEAD;
        step(); idle();
        cmp("oor_wr_q", i_q0, 32'd0);
        i_ce0 = 1; i_we0 = 1; i_address0 = 6'd4; i_d0 = 32'hA5;
        step(); idle();
        cmp("read_first", i_q0, 32'h5A);
        i_ce1 = 1; i_address1 = 6'd7;
        i_ce0 = 1; i_address0 = 6'd40;
        step(); idle();
        cmp("collide_p1", i_q1, 32'h22);
        cmp("oor_rd", i_q0, 32'd0);

        i_ce = 1; i_write = 1;
        step(); idle();
        cmp("push_occ", 32'(occupancy), 32'd1);
        cmp("push_empty_n", 32'(t_empty_n), 32'd1);
        t_ce0 = 1; t_address0 = 6'd4; t_ce1 = 1; t_address1 = 6'd7;
        step(); idle();
        cmp("cons_rd_a5", t_q0, 32'hA5);
        cmp("cons_rd_22", t_q1, 32'h22);
        t_ce = 1; t_read = 1;
        step(); idle();
        cmp("pop_empty_n", 32'(t_empty_n), 32'd0);
        cmp("pop_occ", 32'(occupancy), 32'd0);

        // fill all three buffers
        for (int f = 0; f < 3; f++) begin
            i_ce = 1; i_write = 1; i_ce0 = 1; i_we0 = 1;
            i_address0 = AW'(f); i_d0 = 32'h100 + 32'(f);
            step(); idle();
            cmp("fill_occ", 32'(occupancy), 32'(f + 1));
        end
        cmp("full_flag", 32'(i_full_n), 32'd0);
        i_ce = 1; i_write = 1; i_ce0 = 1; i_we0 = 1; i_address0 = 6'd0; i_d0 = 32'hBAD;
        step(); idle();
        cmp("push_ignored", 32'(occupancy), 32'd3);
        t_ce0 = 1; t_address0 = 6'd0;
        step(); idle();
        cmp("gated_wr", t_q0, 32'h100);

        // full channel with push and pop requested together
        i_ce = 1; i_write = 1; t_ce = 1; t_read = 1;
        step(); idle();
        cmp("fullpp_occ", 32'(occupancy), 32'd2);
        cmp("fullpp_full_n", 32'(i_full_n), 32'd1);

        // steady state streaming with pointer wrap
        for (int k = 0; k < 4; k++) begin
            i_ce = 1; i_write = 1; t_ce = 1; t_read = 1;
            i_ce0 = 1; i_we0 = 1; i_address0 = 6'd5; i_d0 = 32'h200 + 32'(k);
            t_ce0 = 1; t_address0 = 6'd5;
            step(); idle();
            cmp("stream_occ", 32'(occupancy), 32'd2);
            if (k == 2) cmp("wrap_rd_k2", t_q0, 32'h200);
            if (k == 3) cmp("wrap_rd_k3", t_q0, 32'h201);
        end

        // reset in the middle of a frame
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp("rst2_occ", 32'(occupancy), 32'd0);
        cmp("rst2_full_n", 32'(i_full_n), 32'd1);
        cmp("rst2_empty_n", 32'(t_empty_n), 32'd0);
        cmp("rst2_tq0", t_q0, 32'd0);
        cmp("rst2_iq0", i_q0, 32'd0);

`ifdef FFT_PIPO_FLUSH_EN
        for (int f = 0; f < 2; f++) begin
            i_ce = 1; i_write = 1;
            step(); idle();
        end
        i_ce = 1; i_write = 1; t_flush = 1;
        i_ce0 = 1; i_we0 = 1; i_address0 = 6'd9; i_d0 = 32'h333;
        step(); idle();
        cmp("flush_occ", 32'(occupancy), 32'd0);
        cmp("flush_empty_n", 32'(t_empty_n), 32'd0);
        i_ce = 1; i_write = 1; i_ce0 = 1; i_we0 = 1; i_address0 = 6'd9; i_d0 = 32'h444;
        step(); idle();
        t_ce0 = 1; t_address0 = 6'd9;
        step(); idle();
        cmp("flush_iptr_kept", t_q0, 32'h444);
`endif

        step();
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
